// File: rtl/er_ctrl_pkg.sv
// Shared definitions for the executable-region sequencing controller:
// state encoding, register map, CTRL bit positions and default parameters.
package er_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } er_state_t;

    localparam logic [1:0] ADDR_ER_MIN = 2'd0;
    localparam logic [1:0] ADDR_ER_MAX = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_ARM    = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_ERRCLR = 2;

    localparam logic [15:0] SMEM_BASE_DEF     = 16'hA000;
    localparam logic [15:0] SMEM_SIZE_DEF     = 16'h4000;
    localparam logic [15:0] RESET_HANDLER_DEF = 16'h0000;

endpackage

// File: rtl/er_bounds_check.sv
// Combinational legality check of a proposed executable region against the
// secure-memory window and the reset vector.
module er_bounds_check
    import er_ctrl_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE     = SMEM_BASE_DEF,
    parameter logic [15:0] SMEM_SIZE     = SMEM_SIZE_DEF,
    parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF
) (
    input  logic [15:0] er_min,
    input  logic [15:0] er_max,
    output logic        valid
);

    // One extra bit so a window ending at the top of memory cannot wrap.
    localparam logic [16:0] SMEM_MAX = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};

    logic ordered;
    logic outside_smem;
    logic avoids_reset;

    always_comb begin
        ordered      = (er_min < er_max);
        outside_smem = ({1'b0, er_min} > SMEM_MAX) || (er_max < SMEM_BASE);
        avoids_reset = (er_min != RESET_HANDLER) && (er_max != RESET_HANDLER);
        valid        = ordered && outside_smem && avoids_reset;
    end

endmodule

// File: rtl/er_exec_ctrl.sv
// Configuration and sequencing controller for the ER atomicity monitor:
// owns the bounds, tracks entry/exit/violation and publishes EXEC and a run count.
module er_exec_ctrl
    import er_ctrl_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE     = SMEM_BASE_DEF,
    parameter logic [15:0] SMEM_SIZE     = SMEM_SIZE_DEF,
    parameter logic [15:0] RESET_HANDLER = RESET_HANDLER_DEF
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic [15:0] pc,
    input  logic        viol,
    input  logic        cfg_we,
    input  logic        cfg_re,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic [15:0] cfg_rdata,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic        exec,
    output logic        locked
);

    er_state_t   state;
    er_state_t   state_next;
    logic [15:0] prev_pc;
    logic [7:0]  run_cnt;
    logic        bnd_err;
    logic        wr_err;
    logic        bounds_ok;
    logic        ctrl_wr;
    logic        arm;
    logic        clr;
    logic        err_clr;
    logic        bound_wr;
    logic        in_er;
    logic        run_done;
    logic        arm_fail;
    logic [15:0] status_word;

    er_bounds_check #(
        .SMEM_BASE     (SMEM_BASE),
        .SMEM_SIZE     (SMEM_SIZE),
        .RESET_HANDLER (RESET_HANDLER)
    ) u_bounds_check (
        .er_min (er_min),
        .er_max (er_max),
        .valid  (bounds_ok)
    );

    always_comb begin
        ctrl_wr     = cfg_we && (cfg_addr == ADDR_CTRL);
        arm         = ctrl_wr && cfg_wdata[CTRL_ARM];
        clr         = ctrl_wr && cfg_wdata[CTRL_CLR];
        err_clr     = ctrl_wr && cfg_wdata[CTRL_ERRCLR];
        bound_wr    = cfg_we && ((cfg_addr == ADDR_ER_MIN) || (cfg_addr == ADDR_ER_MAX));
        in_er       = (pc >= er_min) && (pc <= er_max);
        status_word = {run_cnt, 2'b00, wr_err, bnd_err, exec, state};
    end

    // Violation overrides everything; CLR outranks ARM and PC-driven moves.
    always_comb begin
        state_next = state;
        run_done   = 1'b0;
        arm_fail   = 1'b0;
        if (viol) begin
            state_next = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm && !clr) begin
                        if (bounds_ok) state_next = ST_ARMED;
                        else           arm_fail   = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (pc == er_min) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (!in_er) begin
                        if (prev_pc == er_max) begin
                            state_next = ST_DONE;
                            run_done   = 1'b1;
                        end else begin
                            state_next = ST_FAULT;
                        end
                    end
                end
                ST_DONE: begin
                    if (clr)                state_next = ST_IDLE;
                    else if (pc == er_min)  state_next = ST_RUN;
                    else if (in_er)         state_next = ST_FAULT;
                end
                ST_FAULT: begin
                    if (clr) state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // EXEC and locked are registered copies of the next state.
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            state   <= ST_IDLE;
            exec    <= 1'b0;
            locked  <= 1'b0;
            prev_pc <= 16'h0000;
            run_cnt <= 8'h00;
        end else begin
            state   <= state_next;
            exec    <= (state_next == ST_DONE);
            locked  <= (state_next != ST_IDLE);
            prev_pc <= pc;
            if (run_done && (run_cnt != 8'hFF)) run_cnt <= run_cnt + 8'h01;
        end
    end

    // Bounds only move while IDLE; a write in any other state is flagged instead.
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            er_min  <= 16'h0000;
            er_max  <= 16'h0000;
            bnd_err <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            if (bound_wr && (state == ST_IDLE)) begin
                if (cfg_addr == ADDR_ER_MIN) er_min <= cfg_wdata;
                else                         er_max <= cfg_wdata;
            end
            if (err_clr) begin
                bnd_err <= 1'b0;
                wr_err  <= 1'b0;
            end
            if (arm_fail) bnd_err <= 1'b1;
            if (bound_wr && (state != ST_IDLE)) wr_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            cfg_rdata <= 16'h0000;
        end else if (cfg_re) begin
            case (cfg_addr)
                ADDR_ER_MIN: cfg_rdata <= er_min;
                ADDR_ER_MAX: cfg_rdata <= er_max;
                ADDR_STATUS: cfg_rdata <= status_word;
                default:     cfg_rdata <= 16'h0000;
            endcase
        end
    end

endmodule

// File: tb/tb_er_exec_ctrl.sv
// Directed self-checking bench for er_exec_ctrl: configuration, arming, clean
// and faulty runs, counter saturation and asynchronous reset.
module tb_er_exec_ctrl;

    logic        clk;
    logic        puc_rst;
    logic [15:0] pc;
    logic        viol;
    logic        cfg_we;
    logic        cfg_re;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic [15:0] er_min;
    logic [15:0] er_max;
    logic        exec;
    logic        locked;

    int testsRun;
    int testsFailed;
    logic [15:0] rd;

    er_exec_ctrl dut (
        .clk       (clk),
        .puc_rst   (puc_rst),
        .pc        (pc),
        .viol      (viol),
        .cfg_we    (cfg_we),
        .cfg_re    (cfg_re),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .er_min    (er_min),
        .er_max    (er_max),
        .exec      (exec),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic cfgWrite(input logic [1:0] addr, input logic [15:0] data);
        cfg_addr  = addr;
        cfg_wdata = data;
        cfg_we    = 1'b1;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
    endtask

    task automatic cfgRead(input logic [1:0] addr, output logic [15:0] data);
        cfg_addr = addr;
        cfg_re   = 1'b1;
        @(posedge clk); #1;
        cfg_re   = 1'b0;
        data     = cfg_rdata;
    endtask

    task automatic applyStimulus(input logic [15:0] p, input logic v);
        pc   = p;
        viol = v;
        @(posedge clk); #1;
        viol = 1'b0;
    endtask

    task automatic cleanRun();
        applyStimulus(16'hE100, 1'b0);
        applyStimulus(16'hE1FE, 1'b0);
        applyStimulus(16'h4000, 1'b0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        puc_rst   = 1'b1;
        pc        = 16'h4000;
        viol      = 1'b0;
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 16'h0000;
        repeat (2) @(posedge clk);
        #1 puc_rst = 1'b0;

        checkOutput("rst_er_min", er_min, 16'h0000);
        checkOutput("rst_er_max", er_max, 16'h0000);
        checkOutput("rst_exec", exec, 1'b0);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_rdata", cfg_rdata, 16'h0000);
        cfgRead(2'd3, rd);
        checkOutput("rst_status", rd, 16'h0000);

        // Clean execution
        cfgWrite(2'd0, 16'hE100);
        cfgWrite(2'd1, 16'hE1FE);
        cfgRead(2'd0, rd);
        checkOutput("rd_er_min", rd, 16'hE100);
        cfgWrite(2'd2, 16'h0001);
        applyStimulus(16'h4000, 1'b0);
        checkOutput("armed_locked", locked, 1'b1);
        cfgRead(2'd3, rd);
        checkOutput("armed_status", rd, 16'h0001);
        applyStimulus(16'hE100, 1'b0);
        applyStimulus(16'hE180, 1'b0);
        applyStimulus(16'hE1FE, 1'b0);
        checkOutput("run_exec", exec, 1'b0);
        applyStimulus(16'h4000, 1'b0);
        checkOutput("done_exec", exec, 1'b1);
        cfgRead(2'd3, rd);
        checkOutput("done_status", rd, 16'h010B);

        // Violation while DONE
        applyStimulus(16'h4000, 1'b1);
        checkOutput("done_viol_exec", exec, 1'b0);
        cfgRead(2'd3, rd);
        checkOutput("done_viol_status", rd, 16'h0104);
        cfgWrite(2'd2, 16'h0002);
        applyStimulus(16'h4000, 1'b0);
        checkOutput("clr_locked", locked, 1'b0);

        // Bounds overlapping secure memory
        cfgWrite(2'd0, 16'hB000);
        cfgWrite(2'd1, 16'hB100);
        cfgWrite(2'd2, 16'h0001);
        applyStimulus(16'h4000, 1'b0);
        checkOutput("bad_arm_locked", locked, 1'b0);
        cfgRead(2'd3, rd);
        checkOutput("bad_arm_status", rd, 16'h0110);
        cfgWrite(2'd2, 16'h0004);
        cfgRead(2'd3, rd);
        checkOutput("errclr_status", rd, 16'h0100);

        // Read and write of the same register in one cycle
        cfg_addr  = 2'd0;
        cfg_wdata = 16'hE100;
        cfg_we    = 1'b1;
        cfg_re    = 1'b1;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        checkOutput("rw_pre_value", cfg_rdata, 16'hB000);
        checkOutput("rw_new_value", er_min, 16'hE100);
        cfgWrite(2'd1, 16'hE1FE);

        // Premature exit, then a locked bound write
        cfgWrite(2'd2, 16'h0001);
        applyStimulus(16'hE100, 1'b0);
        applyStimulus(16'hE110, 1'b0);
        applyStimulus(16'h4000, 1'b0);
        checkOutput("fault_exec", exec, 1'b0);
        cfgWrite(2'd0, 16'h1234);
        checkOutput("locked_er_min", er_min, 16'hE100);
        cfgRead(2'd3, rd);
        checkOutput("fault_status", rd, 16'h0124);
        cfgWrite(2'd2, 16'h0002);
        cfgRead(2'd3, rd);
        checkOutput("fault_clr_status", rd, 16'h0120);
        cfgWrite(2'd2, 16'h0004);

        // ARM together with CLR is ignored
        cfgWrite(2'd2, 16'h0003);
        applyStimulus(16'h4000, 1'b0);
        checkOutput("armclr_locked", locked, 1'b0);
        cfgRead(2'd3, rd);
        checkOutput("armclr_status", rd, 16'h0100);

        // Violation while ARMED
        cfgWrite(2'd2, 16'h0001);
        applyStimulus(16'h4000, 1'b1);
        cfgRead(2'd3, rd);
        checkOutput("armed_viol_status", rd, 16'h0104);
        cfgWrite(2'd2, 16'h0002);

        // Violation coinciding with a clean exit
        cfgWrite(2'd2, 16'h0001);
        applyStimulus(16'hE100, 1'b0);
        applyStimulus(16'hE1FE, 1'b0);
        applyStimulus(16'h4000, 1'b1);
        cfgRead(2'd3, rd);
        checkOutput("exit_viol_status", rd, 16'h0104);
        cfgWrite(2'd2, 16'h0002);

        // Counter saturation
        cfgWrite(2'd2, 16'h0001);
        for (int i = 0; i < 253; i++) cleanRun();
        cfgRead(2'd3, rd);
        checkOutput("cnt_fe_status", rd, 16'hFE0B);
        cleanRun();
        cfgRead(2'd3, rd);
        checkOutput("cnt_ff_status", rd, 16'hFF0B);
        cleanRun();
        cleanRun();
        cfgRead(2'd3, rd);
        checkOutput("cnt_sat_status", rd, 16'hFF0B);

        // Re-entry into the ER away from er_min after DONE
        applyStimulus(16'hE102, 1'b0);
        cfgRead(2'd3, rd);
        checkOutput("done_reenter_status", rd, 16'hFF04);
        cfgWrite(2'd2, 16'h0002);

        // Asynchronous reset between clock edges while running
        cfgWrite(2'd2, 16'h0001);
        applyStimulus(16'hE100, 1'b0);
        cfgRead(2'd3, rd);
        checkOutput("pre_rst_status", rd, 16'hFF02);
        #2 puc_rst = 1'b1;
        #1;
        checkOutput("async_rst_locked", locked, 1'b0);
        checkOutput("async_rst_er_min", er_min, 16'h0000);
        checkOutput("async_rst_er_max", er_max, 16'h0000);
        checkOutput("async_rst_rdata", cfg_rdata, 16'h0000);
        checkOutput("async_rst_exec", exec, 1'b0);
        @(posedge clk); #1;
        puc_rst = 1'b0;
        cfgRead(2'd3, rd);
        checkOutput("post_rst_status", rd, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
